fetch_buffered: RTL
===================

Name: fetch_buffered

Overview:
- Parametrised successor to the pipeline fetch stage.
- Owns the PC register, drives a synchronous instruction-memory port with fixed 1-cycle read latency, and buffers fetched instructions in a DEPTH-entry queue.
- Hands instructions to decode with a valid/ready handshake, so a decode stall no longer stalls the PC directly.
- Execute-stage redirects (branch/JAL target, JALR ALU result) flush the queue and discard the in-flight fetch.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- PCSrcE  in  2  redirect select: 00 sequential, 01 PCTargetE, 10 ALUResultE, 11 reserved (treated as 00).
- PCTargetE  in  XLEN  branch/JAL target.
- ALUResultE  in  XLEN  JALR target; bit 0 forced to 0 before use.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address, valid when imem_req is 1.
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
- ReadyD  in  1  decode accepts the head entry this cycle.
- ValidF  out  1  head entry valid.
- InstrF  out  32  head instruction; 32'h0000_0013 (NOP) when ValidF is 0.
- PCF  out  XLEN  head PC; 0 when ValidF is 0.
- PCPlus4F  out  XLEN  PCF+4; 0 when ValidF is 0.
- QueueCountF  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (asynchronous, rst=0):
  - pc_q=RESET_PC, count=0, inflight=0, pointers=0.
  - Outputs: ValidF=0, InstrF=NOP, PCF=0, PCPlus4F=0, QueueCountF=0, imem_req=0.
- Reset released mid-operation: all state restarts from the reset values; no partial entry survives.
- redirect = (PCSrcE==01 || PCSrcE==10).
- pop = ValidF && ReadyD && !redirect.
- Issue rule: issue = !redirect && (count + inflight - pop < DEPTH).
  - On issue: imem_req=1, imem_addr=pc_q, pc_q<=pc_q+4 (mod 2^XLEN, wraps silently), inflight<=1, inflight_pc<=pc_q.
  - Otherwise: inflight<=0.
- Response: when inflight==1 and no redirect, {inflight_pc, imem_rdata} is written at the tail at the clock edge.
- Simultaneous push and pop: count unchanged; the queue never overflows, guaranteed by the issue rule.
- Redirect cycle:
  - Next-edge effects: count<=0, pointers<=0, pc_q<=target, inflight<=0.
  - The response arriving this cycle is discarded; the pop is ignored.
  - Redirect always wins over pop, push and ReadyD.
  - Decode flushing is handled by the hazard unit.
- Latency:
  - Redirect in cycle N: target issued N+1, enqueued at end of N+2, ValidF=1 in N+3.
  - Reset release: first issue cycle 0, ValidF in cycle 2.
- Throughput: one instruction per cycle sustained with ReadyD=1 for any DEPTH>=2.
- Outputs are driven from registered queue state only; no combinational imem_rdata-to-InstrF bypass.
- Full queue: issue stops; the PC holds.
- Empty queue: ValidF=0 and default output values.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - Extra output InstrMisalignF (1 bit).
  - Each queue entry carries a misalign bit, set when the PC of the fetched entry has bits[1:0]!=0.
  - Such a fetch is still issued to imem (the address is word-aligned by clearing bits[1:0]).
  - InstrMisalignF mirrors the head entry's bit; 0 when ValidF is 0.
- When undefined: the port and bit are absent; misaligned targets are word-aligned silently.

Decomposition:
- Package fetch_pkg:
  - pcsrc_e enum (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_ALU, PCSRC_RSVD).
  - NOP_INSTR constant.
  - fetch_entry_t struct {pc, instr[, misalign]}.
- Sub-module fetch_queue: synchronous FIFO with flush, push/pop, count output, parametrised on DEPTH and entry type.

Test Plan:
- Reset then ReadyD=1, imem returns addr-as-data: ValidF rises in cycle 2; PCF sequence 0,4,8,12 on consecutive cycles; PCPlus4F=PCF+4.
- ReadyD=0 for 10 cycles with DEPTH=4:
  - QueueCountF saturates at 4; imem_req stops after 4 issues.
  - Release ReadyD: PCs 0,4,8,12,16 delivered in order with no gap.
- PCSrcE=01, PCTargetE=0x100 while the queue holds 3 entries and a fetch is in flight:
  - Next cycle QueueCountF=0 and imem_addr=0x100.
  - ValidF with PCF=0x100 three cycles after the redirect; the stale response is not enqueued.
- PCSrcE=10, ALUResultE=0x205: fetch resumes at 0x204; PCF=0x204.
- Redirect asserted in the same cycle as ReadyD=1 and a response arriving: no pop, no push, count=0.
- rst pulsed low mid-stream: outputs return immediately to the reset values; fetch restarts at RESET_PC.
- With FETCH_MISALIGN_EN defined, PCTargetE=0x102: InstrMisalignF=1 with PCF=0x102.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered fetch stage; FETCH_MISALIGN_EN adds a misalign bit per entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_ALU    = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
`ifdef FETCH_MISALIGN_EN
    logic                  misalign;
`endif
  } fetch_entry_t;

  // Reserved encoding falls through to sequential fetch.
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PCSRC_TARGET) || (sel == PCSRC_ALU);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO with flush; head visible same cycle as count!=0, push-to-head 1 cycle.
// No internal backpressure: the producer must never push into a full queue; flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  entry_t                 push_dat,
  input  logic                   pop_vld,
  output entry_t                 head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage: PC, 1-cycle imem port, DEPTH-entry queue to decode; redirect-to-ValidF is 3 cycles.
// Decode stall fills the queue, then issue stops and PC holds. FETCH_MISALIGN_EN adds InstrMisalignF.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             PCSrcE,
  input  logic [XLEN-1:0]        PCTargetE,
  input  logic [XLEN-1:0]        ALUResultE,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   ReadyD,
  output logic                   ValidF,
  output logic [31:0]            InstrF,
  output logic [XLEN-1:0]        PCF,
  output logic [XLEN-1:0]        PCPlus4F,
  output logic [$clog2(DEPTH):0] QueueCountF
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                   InstrMisalignF
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef FETCH_MISALIGN_EN
    logic            misalign;
`endif
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   count;
  entry_t          tail;
  entry_t          head;

  assign redirect = is_redirect(PCSrcE);
  assign valid    = (count != '0);
  assign pop      = valid && ReadyD && !redirect;
  assign push     = inflight && !redirect;

  // Slots already promised (queued plus in flight) after this cycle's pop.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = rst && !redirect && (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    redirect_pc = PCTargetE;
    if (PCSrcE == PCSRC_ALU) redirect_pc = ALUResultE & ~XLEN'(1);
  end

`ifdef FETCH_MISALIGN_EN
  assign next_pc = redirect_pc;
`else
  assign next_pc = redirect_pc & ~XLEN'(3);
`endif

  assign imem_req  = issue;
  assign imem_addr = pc_q & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc_q     <= next_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q        <= pc_q + XLEN'(4);
        inflight_pc <= pc_q;
      end
    end
  end

  always_comb begin
    tail       = '0;
    tail.pc    = inflight_pc;
    tail.instr = imem_rdata;
`ifdef FETCH_MISALIGN_EN
    tail.misalign = |inflight_pc[1:0];
`endif
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push_vld (push),
    .push_dat (tail),
    .pop_vld  (pop),
    .head_dat (head),
    .count    (count)
  );

  always_comb begin
    ValidF   = valid;
    InstrF   = NOP_INSTR;
    PCF      = '0;
    PCPlus4F = '0;
    if (valid) begin
      InstrF   = head.instr;
      PCF      = head.pc;
      PCPlus4F = head.pc + XLEN'(4);
    end
  end

`ifdef FETCH_MISALIGN_EN
  assign InstrMisalignF = valid && head.misalign;
`endif

  assign QueueCountF = count;

endmodule
